// File: rtl/snn_pkg.sv
// Shared definitions for the SNN image loader.
// Holds the image geometry, the input-unit RAM address width and the loader
// FSM state type.
package snn_pkg;

  localparam int unsigned NUM_PIXELS      = 784;
  localparam int unsigned BYTES_PER_IMAGE = NUM_PIXELS / 8;
  localparam int unsigned ADDR_W          = 10;

  typedef enum logic [1:0] {
    RECV,
    UNPACK,
    START,
    WAIT_CORE
  } loader_state_t;

endpackage

// File: rtl/snn_pixel_unpacker.sv
// Byte-to-pixel unpacker: an 8-bit load/shift register emitting one pixel per
// shift (LSB first), a 3-bit bit counter and a one-byte hold buffer that
// absorbs a byte arriving while the current one is still being unpacked.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   load_i        load rx_data_i straight into the shift register
//   shift_i       emit shift[0] this cycle and shift right
//   reload_i      move the hold buffer into the shift register (empties it)
//   hold_wr_i     a byte is offered to the hold buffer this cycle
//   rx_data_i     received byte
//   pixel_o       current pixel (shift[0])
//   last_bit_o    current shift emits bit 7 of the byte
//   hold_full_o   hold buffer holds a byte
//   drop_o        offered byte was dropped because the buffer was full
module snn_pixel_unpacker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       shift_i,
  input  logic       reload_i,
  input  logic       hold_wr_i,
  input  logic [7:0] rx_data_i,
  output logic       pixel_o,
  output logic       last_bit_o,
  output logic       hold_full_o,
  output logic       drop_o
);

  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;

  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    drop_o      = 1'b0;

    // Reload coincides with the final shift of the previous byte, so it wins.
    if (reload_i) begin
      shift_d = hold_q;
      cnt_d   = 3'd0;
    end else if (load_i) begin
      shift_d = rx_data_i;
      cnt_d   = 3'd0;
    end else if (shift_i) begin
      shift_d = {1'b0, shift_q[7:1]};
      cnt_d   = cnt_q + 3'd1;
    end

    // A byte arriving in the cycle the buffer drains is accepted, not dropped.
    if (reload_i) begin
      hold_full_d = 1'b0;
    end
    if (hold_wr_i) begin
      if (!hold_full_d) begin
        hold_d      = rx_data_i;
        hold_full_d = 1'b1;
      end else begin
        drop_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= 8'h00;
      cnt_q       <= 3'd0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  assign pixel_o     = shift_q[0];
  assign last_bit_o  = (cnt_q == 3'd7);
  assign hold_full_o = hold_full_q;

endmodule

// File: rtl/snn_image_loader.sv
// Image loader feeding snn_core: unpacks UART bytes into the 784x1 input-unit
// RAM (byte k bit i -> address 8k+i), starts the core once the image is
// complete, hands the RAM address port to the core while it runs, and
// captures the classified digit.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   rx_rdy         one-cycle pulse, rx_data valid
//   rx_data        received byte, pixels LSB first
//   core_addr      RAM address driven by snn_core while it runs
//   core_done      done pulse from snn_core
//   core_digit     classified digit, valid with core_done
//   ram_addr       input-unit RAM address
//   ram_we         input-unit RAM write enable
//   ram_data       input-unit RAM write data
//   start          one-cycle start pulse to snn_core
//   busy           high in START and WAIT_CORE
//   result_valid   one-cycle pulse, digit updated
//   digit          last classified digit
//   overrun        sticky: a received byte was dropped
module snn_image_loader
  import snn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              core_done,
  input  logic [3:0]        core_digit,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              ram_data,
  output logic              start,
  output logic              busy,
  output logic              result_valid,
  output logic [3:0]        digit,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LastPixel = ADDR_W'(BYTES_PER_IMAGE * 8 - 1);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [3:0]        digit_q, digit_d;
  logic              result_valid_q, result_valid_d;
  logic              overrun_q, overrun_d;

  logic load, shift_en, reload, hold_wr, busy_drop;
  logic pixel, last_bit, hold_full, hold_drop;

  snn_pixel_unpacker u_unpacker (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .shift_i     (shift_en),
    .reload_i    (reload),
    .hold_wr_i   (hold_wr),
    .rx_data_i   (rx_data),
    .pixel_o     (pixel),
    .last_bit_o  (last_bit),
    .hold_full_o (hold_full),
    .drop_o      (hold_drop)
  );

  always_comb begin
    state_d        = state_q;
    wptr_d         = wptr_q;
    digit_d        = digit_q;
    result_valid_d = 1'b0;
    load           = 1'b0;
    shift_en       = 1'b0;
    reload         = 1'b0;
    hold_wr        = 1'b0;
    busy_drop      = 1'b0;

    unique case (state_q)
      RECV: begin
        // A byte parked in the hold buffer during the final UNPACK of the
        // previous image is consumed before any new byte.
        if (hold_full) begin
          reload  = 1'b1;
          hold_wr = rx_rdy;
          state_d = UNPACK;
        end else if (rx_rdy) begin
          load    = 1'b1;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        shift_en = 1'b1;
        hold_wr  = rx_rdy;
        wptr_d   = wptr_q + ADDR_W'(1);
        if (last_bit) begin
          if (wptr_q == LastPixel) begin
            state_d = START;
          end else if (hold_full) begin
            reload = 1'b1;
          end else begin
            state_d = RECV;
          end
        end
      end
      START: begin
        busy_drop = rx_rdy;
        wptr_d    = '0;
        state_d   = WAIT_CORE;
      end
      WAIT_CORE: begin
        busy_drop = rx_rdy;
        if (core_done) begin
          digit_d        = core_digit;
          result_valid_d = 1'b1;
          state_d        = RECV;
        end
      end
      default: state_d = RECV;
    endcase

    overrun_d = overrun_q | hold_drop | busy_drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RECV;
      wptr_q         <= '0;
      digit_q        <= 4'd0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      wptr_q         <= wptr_d;
      digit_q        <= digit_d;
      result_valid_q <= result_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  // The core owns the address port for the whole START..WAIT_CORE span; the
  // write enable is only ever raised in UNPACK, so it never collides.
  assign busy         = (state_q == START) || (state_q == WAIT_CORE);
  assign ram_addr     = busy ? core_addr : wptr_q;
  assign ram_we       = (state_q == UNPACK);
  assign ram_data     = pixel;
  assign start        = (state_q == START);
  assign result_valid = result_valid_q;
  assign digit        = digit_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_snn_image_loader.sv
// Directed bench for snn_image_loader with a behavioural input-unit RAM.
module tb_snn_image_loader;
  import snn_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              rx_rdy = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic [ADDR_W-1:0] core_addr = '0;
  logic              core_done = 1'b0;
  logic [3:0]        core_digit = 4'd0;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic              ram_data;
  logic              start;
  logic              busy;
  logic              result_valid;
  logic [3:0]        digit;
  logic              overrun;

  snn_image_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_rdy       (rx_rdy),
    .rx_data      (rx_data),
    .core_addr    (core_addr),
    .core_done    (core_done),
    .core_digit   (core_digit),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_data     (ram_data),
    .start        (start),
    .busy         (busy),
    .result_valid (result_valid),
    .digit        (digit),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM with per-address written flags.
  logic mem [0:1023];
  logic wr  [0:1023];
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_data;
      wr[ram_addr]  <= 1'b1;
    end
  end

  int   start_cnt = 0, start_cyc = 0, we_cnt = 0, we_rise = 0, we_busy = 0;
  logic we_prev = 1'b0;
  always @(negedge clk) begin
    if (start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (ram_we) we_cnt++;
    if (ram_we && !we_prev) we_rise++;
    if (ram_we && busy) we_busy++;
    we_prev = ram_we;
  end

  int n_chk = 0, n_fail = 0, last_rx = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    last_rx = cyc;
    tick();
    rx_rdy  = 1'b0;
  endtask

  function automatic logic [7:0] byte_of(input int kind, input int k);
    if (kind == 0) return 8'hA5;
    return 8'((k * 37 + 3) & 255);
  endfunction

  task automatic send_image(input int kind, input int first, input int n);
    for (int k = first; k < first + n; k++) begin
      send_byte(byte_of(kind, k));
      repeat (10) tick();
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 1024; a++) begin
      mem[a] = 1'b0;
      wr[a]  = 1'b0;
    end
  endtask

  task automatic check_img(input string tag, input int kind);
    int         bad;
    logic [7:0] b;
    bad = 0;
    for (int a = 0; a < NUM_PIXELS; a++) begin
      b = byte_of(kind, a / 8);
      if (!wr[a] || mem[a] !== b[a % 8]) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_ram_addr"}, int'(ram_addr), 0);
    check({pfx, "_start"}, int'(start), 0);
    check({pfx, "_ram_we"}, int'(ram_we), 0);
    check({pfx, "_ram_data"}, int'(ram_data), 0);
    check({pfx, "_result_valid"}, int'(result_valid), 0);
    check({pfx, "_busy"}, int'(busy), 0);
    check({pfx, "_digit"}, int'(digit), 0);
    check({pfx, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    int         bad;
    logic [7:0] b0, b1;

    clear_mem();
    #2 rst_n = 1'b0;
    #2 check_reset("rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Image 1: 98 x 0xA5, then core handoff.
    start_cnt = 0;
    send_image(0, 0, BYTES_PER_IMAGE);
    check("img1_start_cnt", start_cnt, 1);
    check("img1_start_lat", start_cyc - last_rx, 9);
    check_img("img1_ram", 0);
    check("img1_busy", int'(busy), 1);
    check("img1_overrun", int'(overrun), 0);
    core_addr = 10'h022;
    #1 check("hand_addr_22", int'(ram_addr), 'h22);
    check("hand_we_22", int'(ram_we), 0);
    core_addr = 10'h305;
    #1 check("hand_addr_305", int'(ram_addr), 'h305);
    check("hand_we_305", int'(ram_we), 0);
    core_digit = 4'd7;
    core_done  = 1'b1;
    tick();
    core_done = 1'b0;
    check("done_rv", int'(result_valid), 1);
    check("done_digit", int'(digit), 7);
    check("done_busy", int'(busy), 0);
    check("done_addr", int'(ram_addr), 0);
    tick();
    check("done_rv_pulse", int'(result_valid), 0);

    // Burst: 0x01 then 0xFF on consecutive cycles.
    clear_mem();
    we_cnt  = 0;
    we_rise = 0;
    rx_data = 8'h01;
    rx_rdy  = 1'b1;
    tick();
    rx_data = 8'hFF;
    tick();
    rx_rdy = 1'b0;
    repeat (20) tick();
    bad = 0;
    for (int a = 0; a < 16; a++) begin
      if (!wr[a] || mem[a] !== ((a == 0 || a >= 8) ? 1'b1 : 1'b0)) bad++;
    end
    check("burst_ram", bad, 0);
    check("burst_we_cnt", we_cnt, 16);
    check("burst_no_gap", we_rise, 1);
    check("burst_overrun", int'(overrun), 0);
    check("burst_wptr", int'(ram_addr), 16);

    // Overrun: three bytes on consecutive cycles, third is dropped.
    we_cnt = 0;
    b0 = 8'h0F;
    b1 = 8'hF0;
    rx_data = b0;
    rx_rdy  = 1'b1;
    tick();
    rx_data = b1;
    tick();
    rx_data = 8'h33;
    tick();
    rx_rdy = 1'b0;
    repeat (20) tick();
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (!wr[16 + i] || mem[16 + i] !== b0[i]) bad++;
      if (!wr[24 + i] || mem[24 + i] !== b1[i]) bad++;
    end
    check("ovr_ram", bad, 0);
    check("ovr_flag", int'(overrun), 1);
    check("ovr_wptr", int'(ram_addr), 32);
    check("ovr_we_cnt", we_cnt, 16);
    repeat (20) tick();
    check("ovr_sticky", int'(overrun), 1);

    // Bring the image to 40 bytes, then reset mid-image.
    send_image(1, 4, 36);
    check("mid_wptr", int'(ram_addr), 320);
    rst_n = 1'b0;
    #2 check_reset("mid");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Image 2 after reset, byte during WAIT_CORE, ignored done outside WAIT.
    clear_mem();
    start_cnt = 0;
    we_busy   = 0;
    send_image(1, 0, BYTES_PER_IMAGE);
    check("img2_start_cnt", start_cnt, 1);
    check("img2_start_lat", start_cyc - last_rx, 9);
    check_img("img2_ram", 1);
    check("img2_overrun", int'(overrun), 0);
    send_byte(8'h55);
    tick();
    check("busy_rx_overrun", int'(overrun), 1);
    check("busy_rx_busy", int'(busy), 1);
    check("busy_rx_start", start_cnt, 1);
    core_digit = 4'd3;
    core_done  = 1'b1;
    tick();
    core_done = 1'b0;
    check("img2_rv", int'(result_valid), 1);
    check("img2_digit", int'(digit), 3);
    core_digit = 4'd9;
    core_done  = 1'b1;
    tick();
    core_done = 1'b0;
    check("stray_done_rv", int'(result_valid), 0);
    check("stray_done_digit", int'(digit), 3);
    clear_mem();
    send_byte(8'h80);
    repeat (10) tick();
    check("next_addr0", int'(wr[0] && mem[0] == 1'b0), 1);
    check("next_addr7", int'(wr[7] && mem[7] == 1'b1), 1);
    check("next_wptr", int'(ram_addr), 8);
    check("we_while_busy", we_busy, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/snn_image_loader.md
Name: snn_image_loader

Overview:
Upstream feeder for snn_core. It takes 8-bit bytes from the UART receiver and unpacks each byte into 8 one-bit pixels. The pixels are written into the 784x1 input-unit RAM. When a full image is stored, the block pulses start to snn_core, waits for done, then captures the classified digit.
While snn_core runs, the block hands the RAM address port to the core.

Parameters:
NUM_PIXELS, 784, pixels per image (must be a multiple of 8)
ADDR_W, 10, input-unit RAM address width

Ports:
clk  input  1  system clock, all state updates on posedge
rst_n  input  1  asynchronous active-low reset
rx_rdy  input  1  one-cycle pulse, rx_data valid
rx_data  input  8  received byte, pixel bits LSB first
core_addr  input  ADDR_W  addr_input_unit from snn_core
core_done  input  1  done pulse from snn_core
core_digit  input  4  digit from snn_core, valid when core_done=1
ram_addr  output  ADDR_W  input-unit RAM address
ram_we  output  1  input-unit RAM write enable
ram_data  output  1  input-unit RAM write data
start  output  1  one-cycle start pulse to snn_core
busy  output  1  high from START through WAIT_CORE
result_valid  output  1  one-cycle pulse, digit updated
digit  output  4  last classified digit
overrun  output  1  sticky, a byte was dropped

Behaviour:
- Reset values (async, rst_n low): state=RECV, write pointer=0, hold buffer empty.
- Reset values of outputs: start=0, ram_we=0, ram_data=0, result_valid=0, busy=0, digit=0, overrun=0.
- ram_addr equals the write pointer (0) in RECV at reset.
- Reset mid-image discards all progress; the next byte is treated as byte 0.
- Pixel mapping: byte k, bit i goes to RAM address 8k+i. Byte 0 bit 0 is pixel 0. There are NUM_PIXELS/8 = 98 bytes per image.
- State RECV:
  - ram_we=0.
  - On rx_rdy, capture rx_data into the shift register, go to UNPACK next cycle.
- State UNPACK, exactly 8 cycles:
  - Each cycle: ram_we=1, ram_addr=write pointer, ram_data=shift[0].
  - Each cycle: shift right by one, write pointer increments by one.
  - After the 8th write, if pixel NUM_PIXELS-1 was written, go to START.
  - Else, if the hold buffer is full, load it into the shift register, mark it empty, and stay in UNPACK (no idle cycle).
  - Else go to RECV.
- Hold buffer (one byte):
  - rx_rdy during UNPACK with the buffer empty stores the byte.
  - rx_rdy with the buffer full drops the byte and sets overrun.
  - rx_rdy in the same cycle the buffer is being loaded into the shift register is stored; it is not an overrun.
- State START:
  - start=1 for one cycle, busy=1.
  - Write pointer wraps to 0.
  - ram_addr=core_addr from this cycle onward. The mux selects core_addr for the whole START..WAIT_CORE span.
  - Go to WAIT_CORE.
- State WAIT_CORE:
  - busy=1, ram_we=0, ram_addr=core_addr.
  - On core_done, register digit<=core_digit and pulse result_valid the next cycle.
  - Then go to RECV with ram_addr back on the write pointer.
- Any rx_rdy in START or WAIT_CORE is dropped and sets overrun.
- overrun is cleared only by reset.
- Latency: 98th byte rx_rdy at cycle t → writes at t+1..t+8 → start=1 at t+9.
- core_done at cycle d → digit and result_valid updated at d+1 → RECV accepts a byte from d+1.
- core_done outside WAIT_CORE is ignored.
- ram_we is never high while ram_addr is sourced from core_addr.

Decomposition:
- Package snn_pkg holds:
  - NUM_PIXELS and BYTES_PER_IMAGE=NUM_PIXELS/8
  - ADDR_W
  - typedef enum loader_state_t {RECV, UNPACK, START, WAIT_CORE}
- One sub-module, snn_pixel_unpacker: 8-bit load/shift register with a 3-bit bit counter, a last_bit flag, and the one-byte hold buffer.
- The FSM, write pointer, address mux and result capture live in the top level.

Test Plan:
- Single image: send 98 bytes 0xA5 back-to-back with 10-cycle gaps.
  - RAM shows bits 1,0,1,0,0,1,0,1 repeating at addresses 0..783.
  - start pulses once, at 9 cycles after the 98th rx_rdy.
- Burst into buffer: rx_rdy on consecutive cycles for bytes 0x01 and 0xFF.
  - Address 0=1, 1..7=0, 8..15=1.
  - No idle cycle between the two UNPACK runs.
  - overrun=0.
- Overrun: three rx_rdy pulses within 3 cycles.
  - The third byte is dropped and overrun=1 sticky.
  - The write pointer advances by only 16.
- Core handoff: during WAIT_CORE drive core_addr=0x22 then 0x305.
  - ram_addr follows with ram_we=0.
  - core_done with core_digit=7 → digit=7 and result_valid high one cycle.
  - The next byte lands at address 0.
- Byte during busy: rx_rdy in WAIT_CORE.
  - The byte is dropped and overrun=1.
  - After core_done, the next image still starts at address 0.
- Reset mid-image: assert rst_n low after 40 bytes.
  - All outputs return to reset values.
  - A following 98-byte image yields start exactly once, with correct RAM contents.
